// File: rtl/ysyx_24100006_pipe_buf.sv
// rtl/ysyx_24100006_pipe_buf.sv - DEPTH-entry elastic valid/ready pipeline stage with flush
// Optional performance counters are enabled by defining PIPE_BUF_PERF_EN.
module ysyx_24100006_pipe_buf #(
  parameter int DATA_W       = 64,
  parameter int DEPTH        = 1,
  parameter int BYPASS_READY = 1
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       flush_i,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W-1:0]          data_i,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          data_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
`ifdef PIPE_BUF_PERF_EN
  ,
  output logic [31:0]                stall_cnt_o,
  output logic [31:0]                bubble_cnt_o,
  output logic [31:0]                flush_cnt_o
`endif
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic [CW-1:0]     count;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;

  // Explicit wrap so non-power-of-2 depths never index past DEPTH-1.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign in_ready  = !flush_i && (!full || ((BYPASS_READY != 0) && out_ready));
  assign out_valid = !empty && !flush_i;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign data_o    = empty ? '0 : mem[rd_ptr];
  assign count_o   = count;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush_i) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= data_i;
        wr_ptr      <= next_ptr(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (!push && pop) begin
        count <= count - CW'(1);
      end
    end
  end

`ifdef PIPE_BUF_PERF_EN
  // Saturating counters; flush does not clear them.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stall_cnt_o  <= '0;
      bubble_cnt_o <= '0;
      flush_cnt_o  <= '0;
    end else begin
      if (out_valid && !out_ready && (stall_cnt_o != 32'hFFFF_FFFF)) begin
        stall_cnt_o <= stall_cnt_o + 32'd1;
      end
      if (!out_valid && out_ready && !flush_i && (bubble_cnt_o != 32'hFFFF_FFFF)) begin
        bubble_cnt_o <= bubble_cnt_o + 32'd1;
      end
      if (flush_i && !empty && (flush_cnt_o != 32'hFFFF_FFFF)) begin
        flush_cnt_o <= flush_cnt_o + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ysyx_24100006_pipe_buf.sv
// tb/tb_ysyx_24100006_pipe_buf.sv - scoreboard bench for three pipe_buf configurations
module tb_ysyx_24100006_pipe_buf;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  // a: DEPTH=1 bypass, b: DEPTH=2 no bypass, c: DEPTH=3 bypass
  logic       a_flush = 0, a_in_valid = 0, a_in_ready, a_out_valid, a_out_ready = 0;
  logic [7:0] a_data_i = 0, a_data_o;
  logic [0:0] a_count;
  logic       b_flush = 0, b_in_valid = 0, b_in_ready, b_out_valid, b_out_ready = 0;
  logic [7:0] b_data_i = 0, b_data_o;
  logic [1:0] b_count;
  logic       c_flush = 0, c_in_valid = 0, c_in_ready, c_out_valid, c_out_ready = 0;
  logic [7:0] c_data_i = 0, c_data_o;
  logic [1:0] c_count;
`ifdef PIPE_BUF_PERF_EN
  logic [31:0] a_stall, a_bubble, a_fl, b_stall, b_bubble, b_fl, c_stall, c_bubble, c_fl;
`endif

  logic [7:0] q_a[$];
  logic [7:0] q_b[$];
  logic [7:0] q_c[$];

  ysyx_24100006_pipe_buf #(.DATA_W(8), .DEPTH(1), .BYPASS_READY(1)) u_a (
    .clk(clk), .reset_n(rst_n), .flush_i(a_flush), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .data_i(a_data_i), .out_valid(a_out_valid), .out_ready(a_out_ready), .data_o(a_data_o),
    .count_o(a_count)
`ifdef PIPE_BUF_PERF_EN
    , .stall_cnt_o(a_stall), .bubble_cnt_o(a_bubble), .flush_cnt_o(a_fl)
`endif
  );

  ysyx_24100006_pipe_buf #(.DATA_W(8), .DEPTH(2), .BYPASS_READY(0)) u_b (
    .clk(clk), .reset_n(rst_n), .flush_i(b_flush), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .data_i(b_data_i), .out_valid(b_out_valid), .out_ready(b_out_ready), .data_o(b_data_o),
    .count_o(b_count)
`ifdef PIPE_BUF_PERF_EN
    , .stall_cnt_o(b_stall), .bubble_cnt_o(b_bubble), .flush_cnt_o(b_fl)
`endif
  );

  ysyx_24100006_pipe_buf #(.DATA_W(8), .DEPTH(3), .BYPASS_READY(1)) u_c (
    .clk(clk), .reset_n(rst_n), .flush_i(c_flush), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .data_i(c_data_i), .out_valid(c_out_valid), .out_ready(c_out_ready), .data_o(c_data_o),
    .count_o(c_count)
`ifdef PIPE_BUF_PERF_EN
    , .stall_cnt_o(c_stall), .bubble_cnt_o(c_bubble), .flush_cnt_o(c_fl)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic monitor_pop(input string name, input logic [7:0] act, inout logic [7:0] q[$]);
    vectors++;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL %s: unexpected output %0h, scoreboard empty", name, act);
    end else begin
      logic [7:0] exp;
      exp = q.pop_front();
      if (act !== exp) begin
        errors++;
        $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
    end
  endtask

  // Monitors: a handshake is decided on the next rising edge, so sample here.
  always @(negedge clk) if (rst_n && a_out_valid && a_out_ready) monitor_pop("a_data", a_data_o, q_a);
  always @(negedge clk) if (rst_n && b_out_valid && b_out_ready) monitor_pop("b_data", b_data_o, q_b);
  always @(negedge clk) if (rst_n && c_out_valid && c_out_ready) monitor_pop("c_data", c_data_o, q_c);

  task automatic push_b(input logic [7:0] d);
    b_in_valid = 1'b1;
    b_data_i   = d;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (b_in_ready) begin
        q_b.push_back(d);
        @(posedge clk); #1;
        b_in_valid = 1'b0;
        return;
      end
    end
    check("b_push_timeout", 32'd1, 32'd0);
    b_in_valid = 1'b0;
  endtask

  task automatic push_c(input logic [7:0] d);
    c_in_valid = 1'b1;
    c_data_i   = d;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (c_in_ready) begin
        q_c.push_back(d);
        @(posedge clk); #1;
        c_in_valid = 1'b0;
        return;
      end
    end
    check("c_push_timeout", 32'd1, 32'd0);
    c_in_valid = 1'b0;
  endtask

  task automatic drain(input string name, input int which);
    int n;
    for (int i = 0; i < 30; i++) begin
      n = (which == 0) ? q_a.size() : (which == 1) ? q_b.size() : q_c.size();
      if (n == 0) break;
      @(negedge clk);
    end
    @(negedge clk);
    n = (which == 0) ? q_a.size() : (which == 1) ? q_b.size() : q_c.size();
    check(name, n, 0);
  endtask

  logic [7:0] t1_vals [3];

  initial begin
    t1_vals[0] = 8'h11; t1_vals[1] = 8'h22; t1_vals[2] = 8'h33;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state
    @(negedge clk);
    check("rst_a_in_ready", a_in_ready, 1);
    check("rst_b_out_valid", b_out_valid, 0);
    check("rst_b_data", b_data_o, 0);
    check("rst_b_count", b_count, 0);
    @(posedge clk); #1;

    // DEPTH=1 bypass: back-to-back pushes at full rate
    a_out_ready = 1'b1;
    a_in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a_data_i = t1_vals[i];
      @(negedge clk);
      check("t1_in_ready", a_in_ready, 1);
      if (i == 0) check("t1_no_comb_path", a_out_valid, 0);
      else        check("t1_count", a_count, 1);
      if (a_in_ready) q_a.push_back(t1_vals[i]);
      @(posedge clk); #1;
    end
    a_in_valid = 1'b0;
    drain("t1_drain", 0);
    @(posedge clk); #1;

    // DEPTH=2 no bypass: third item held until a slot frees
    b_out_ready = 1'b0;
    push_b(8'h0A);
    push_b(8'h0B);
    b_in_valid = 1'b1;
    b_data_i   = 8'h0C;
    @(negedge clk);
    check("t2_full_count", b_count, 2);
    check("t2_full_in_ready", b_in_ready, 0);
    @(posedge clk); #1;
    b_out_ready = 1'b1;
    push_b(8'h0C);
    drain("t2_drain", 1);
    @(posedge clk); #1;

    // DEPTH=3 wrap: fill, then stream 4..10 at full rate
    c_out_ready = 1'b0;
    for (int v = 1; v <= 3; v++) push_c(8'(v));
    @(negedge clk);
    check("t3_full_count", c_count, 3);
    check("t3_full_in_ready", c_in_ready, 0);
    @(posedge clk); #1;
    c_out_ready = 1'b1;
    for (int v = 4; v <= 10; v++) push_c(8'(v));
    drain("t3_drain", 2);
    @(posedge clk); #1;
    c_out_ready = 1'b0;

    // Flush while full, with a concurrent push that must be dropped
    b_out_ready = 1'b0;
    push_b(8'h05);
    push_b(8'h06);
    b_flush    = 1'b1;
    b_in_valid = 1'b1;
    b_data_i   = 8'h07;
    @(negedge clk);
    check("t4_flush_out_valid", b_out_valid, 0);
    check("t4_flush_in_ready", b_in_ready, 0);
    q_b.delete();
    @(posedge clk); #1;
    b_flush    = 1'b0;
    b_in_valid = 1'b0;
    @(negedge clk);
    check("t4_post_count", b_count, 0);
    check("t4_post_data", b_data_o, 0);
    check("t4_post_out_valid", b_out_valid, 0);
    @(posedge clk); #1;
    b_out_ready = 1'b1;
    push_b(8'h08);
    drain("t4_drain", 1);
    @(posedge clk); #1;
    b_out_ready = 1'b0;

    // Reset while full
    push_b(8'h01);
    push_b(8'h02);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    q_b.delete();
    @(negedge clk);
    check("t5_count", b_count, 0);
    check("t5_out_valid", b_out_valid, 0);
    check("t5_data", b_data_o, 0);
    check("t5_in_ready", b_in_ready, 1);
    @(posedge clk); #1;

`ifdef PIPE_BUF_PERF_EN
    // 3 stall cycles, 2 bubble cycles, 1 flush with an entry present
    push_b(8'h01);
    repeat (3) @(posedge clk);
    #1 b_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 b_out_ready = 1'b0;
    push_b(8'h02);
    b_flush = 1'b1;
    q_b.delete();
    @(posedge clk); #1;
    b_flush = 1'b0;
    @(negedge clk);
    check("perf_stall", b_stall, 3);
    check("perf_bubble", b_bubble, 2);
    check("perf_flush", b_fl, 1);
`endif

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
